ex_muldiv: RTL and testbench

- Multi-cycle RV32M multiply/divide unit inside the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the decoded operands and M-extension sub-op that ID/EX presents to EX.
- Holds the pipeline through the stall controller (stallreq_o drives the EX stall request) until the result is ready.
- Result is muxed into the EX write-back data path.

---
 rtl/ex_muldiv.sv | 164 ++++++++++++++++
 tb/tb_ex_muldiv.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// RV32M multiply/divide unit for the EX stage: one-cycle multiply, 32-step restoring divide.
// Latency from the acceptance cycle T: ready_o at T+2 (mul), T+33 (div), T+1 (div-by-zero/overflow).
// Stalls the pipeline through stallreq_o until DONE; flush or dropped start_i aborts with no result.
module ex_muldiv #(
  parameter int XLEN      = 32,
  parameter int DIV_CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [XLEN-1:0] result_o,
  output logic            ready_o,
  output logic            stallreq_o
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             op_q, op_d;
  logic [XLEN-1:0]        a_q, a_d;        // multiplicand, or dividend shifting into quotient
  logic [XLEN-1:0]        b_q, b_d;        // multiplier, or divisor magnitude
  logic [XLEN-1:0]        rem_q, rem_d;    // partial remainder
  logic [XLEN-1:0]        result_q, result_d;
  logic                   qneg_q, qneg_d;  // negate quotient at the end
  logic                   rneg_q, rneg_d;  // negate remainder at the end
  logic [DIV_CNT_W-1:0]   cnt_q, cnt_d;

  // Operand preparation for acceptance in IDLE (DIV/REM are the signed divides: op[2]=1, op[0]=0)
  logic            div_signed;
  logic            rs1_neg, rs2_neg;
  logic [XLEN-1:0] rs1_mag, rs2_mag;
  logic            div_zero, div_ovf;

  assign div_signed = op_i[2] & ~op_i[0];
  assign rs1_neg    = div_signed & rs1_i[XLEN-1];
  assign rs2_neg    = div_signed & rs2_i[XLEN-1];
  assign rs1_mag    = rs1_neg ? (~rs1_i + 1'b1) : rs1_i;
  assign rs2_mag    = rs2_neg ? (~rs2_i + 1'b1) : rs2_i;
  assign div_zero   = (rs2_i == '0);
  assign div_ovf    = div_signed & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2_i);

  // Multiplier: sign-extend each operand by one bit according to the sub-op
  logic signed [XLEN:0]     mul_a, mul_b;
  logic signed [2*XLEN-1:0] prod;

  assign mul_a = {((op_q == 3'd1) || (op_q == 3'd2)) & a_q[XLEN-1], a_q};
  assign mul_b = {(op_q == 3'd1) & b_q[XLEN-1], b_q};
  assign prod  = mul_a * mul_b;

  // One restoring divide step on magnitudes
  logic [XLEN:0]   trial;
  logic            qbit;
  logic [XLEN-1:0] rem_next, quo_next, quo_fix, rem_fix;

  assign trial    = {rem_q, a_q[XLEN-1]} - {1'b0, b_q};
  assign qbit     = ~trial[XLEN];
  assign rem_next = qbit ? trial[XLEN-1:0] : {rem_q[XLEN-2:0], a_q[XLEN-1]};
  assign quo_next = {a_q[XLEN-2:0], qbit};
  assign quo_fix  = qneg_q ? (~quo_next + 1'b1) : quo_next;
  assign rem_fix  = rneg_q ? (~rem_next + 1'b1) : rem_next;

  // Next-state and datapath updates; flush overrides everything at the end
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    result_d = result_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !flush) begin
          op_d = op_i;
          if (!op_i[2]) begin
            a_d     = rs1_i;
            b_d     = rs2_i;
            state_d = S_MUL;
          end else if (div_zero || div_ovf) begin
            // op[1] selects the remainder forms (REM/REMU)
            if (op_i[1]) result_d = div_zero ? rs1_i : '0;
            else         result_d = div_zero ? '1 : rs1_i;
            state_d = S_DONE;
          end else begin
            a_d     = rs1_mag;
            b_d     = rs2_mag;
            rem_d   = '0;
            cnt_d   = '0;
            qneg_d  = rs1_neg ^ rs2_neg;
            rneg_d  = rs1_neg;
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        if (!start_i) begin
          state_d = S_IDLE;
        end else begin
          result_d = (op_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          state_d  = S_DONE;
        end
      end
      S_DIV: begin
        if (!start_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          a_d   = quo_next;
          rem_d = rem_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            result_d = op_q[1] ? rem_fix : quo_fix;
            cnt_d    = '0;
            state_d  = S_DONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (flush) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      result_q <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      cnt_q    <= cnt_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = (state_q == S_DONE);
  assign stallreq_o = start_i & ~flush & ~rst & (state_q != S_DONE);

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: scoreboarded results, latency and stall-window checks per scenario.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i, rs2_i;
  logic [31:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(32), .DIV_CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .start_i   (start_i),
    .op_i      (op_i),
    .rs1_i     (rs1_i),
    .rs2_i     (rs2_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .stallreq_o(stallreq_o)
  );

  // Every ready pulse delivers one result into the observed queue
  always @(negedge clk) begin
    if (ready_o) obs_q.push_back(result_o);
  end

  // Drive one operation from an IDLE cycle; operands are scrambled after acceptance.
  // lat = cycle offset of ready_o, first_low = first offset where stallreq_o was low.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit keep,
                       output int lat, output int first_low);
    exp_q.push_back(exp);
    @(posedge clk); #1;
    start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
    lat = -1; first_low = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!stallreq_o && first_low < 0) first_low = k;
      if (ready_o) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
      rs1_i = $urandom; rs2_i = $urandom; op_i = 3'($urandom);
    end
    if (!keep || lat < 0) begin
      @(posedge clk); #1;
      start_i = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; start_i = 1'b1; op_i = 3'd4; rs1_i = 32'd9; rs2_i = 32'd2;
    #12;
    n_cmp++;
    if (ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", ready_o); end
    n_cmp++;
    if (result_o !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h want 0", result_o); end
    n_cmp++;
    if (stallreq_o !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stallreq_o); end
    start_i = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_mul;
    logic [2:0]  ops  [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [31:0] exps [4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    int lat, fl;
    logic [31:0] e, g;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], 32'hFFFFFFFF, 32'd2, exps[i], 1'b0, lat, fl);
      n_cmp++;
      if (lat !== 2) begin n_bad++; $display("FAIL mul%0d_latency: got %0d want 2", ops[i], lat); end
      n_cmp++;
      if (fl !== 2) begin n_bad++; $display("FAIL mul%0d_stall_window: stall dropped at %0d want 2", ops[i], fl); end
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL mul%0d_result: no result want %h", ops[i], e); end
      else begin
        g = obs_q.pop_front();
        if (g !== e) begin n_bad++; $display("FAIL mul%0d_result: got %h want %h", ops[i], g, e); end
      end
    end
  endtask

  task automatic test_div;
    logic [2:0]  ops  [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] exps [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'h00000001};
    int lat, fl;
    logic [31:0] e, g;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], 32'hFFFFFFF9, 32'd2, exps[i], 1'b0, lat, fl);
      n_cmp++;
      if (lat !== 33) begin n_bad++; $display("FAIL div%0d_latency: got %0d want 33", ops[i], lat); end
      n_cmp++;
      if (fl !== 33) begin n_bad++; $display("FAIL div%0d_stall_window: stall dropped at %0d want 33", ops[i], fl); end
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL div%0d_result: no result want %h", ops[i], e); end
      else begin
        g = obs_q.pop_front();
        if (g !== e) begin n_bad++; $display("FAIL div%0d_result: got %h want %h", ops[i], g, e); end
      end
    end
  endtask

  task automatic test_special;
    logic [2:0]  ops  [4] = '{3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] as   [4] = '{32'd1234, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] bs   [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exps [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
    int lat, fl;
    logic [31:0] e, g;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i], exps[i], 1'b0, lat, fl);
      n_cmp++;
      if (lat !== 1) begin n_bad++; $display("FAIL special%0d_latency: got %0d want 1", i, lat); end
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL special%0d_result: no result want %h", i, e); end
      else begin
        g = obs_q.pop_front();
        if (g !== e) begin n_bad++; $display("FAIL special%0d_result: got %h want %h", i, g, e); end
      end
    end
  endtask

  task automatic test_flush;
    int lat, fl;
    logic [31:0] e, g;
    @(posedge clk); #1;
    start_i = 1'b1; op_i = 3'd4; rs1_i = 32'd1000; rs2_i = 32'd3;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (stallreq_o !== 1'b0) begin n_bad++; $display("FAIL flush_stall: got %b want 0", stallreq_o); end
    @(posedge clk); #1;
    flush = 1'b0; start_i = 1'b0;
    repeat (40) @(negedge clk);
    n_cmp++;
    if (obs_q.size() != 0) begin n_bad++; $display("FAIL flush_no_ready: got %0d pulses want 0", obs_q.size()); end
    obs_q.delete();
    issue(3'd3, 32'd3, 32'd5, 32'h0, 1'b0, lat, fl);
    n_cmp++;
    if (lat !== 2) begin n_bad++; $display("FAIL flush_mulhu_latency: got %0d want 2", lat); end
    e = exp_q.pop_front();
    n_cmp++;
    if (obs_q.size() == 0) begin n_bad++; $display("FAIL flush_mulhu_result: no result want %h", e); end
    else begin
      g = obs_q.pop_front();
      if (g !== e) begin n_bad++; $display("FAIL flush_mulhu_result: got %h want %h", g, e); end
    end
  endtask

  task automatic test_back_to_back;
    int lat1, fl1, lat2, fl2;
    logic [31:0] e, g;
    issue(3'd5, 32'd100, 32'd7, 32'd14, 1'b1, lat1, fl1);
    issue(3'd0, 32'd6, 32'd7, 32'd42, 1'b0, lat2, fl2);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (lat1 !== 33) begin n_bad++; $display("FAIL b2b_divu_latency: got %0d want 33", lat1); end
    n_cmp++;
    if (lat2 !== 2) begin n_bad++; $display("FAIL b2b_mul_latency: got %0d want 2", lat2); end
    n_cmp++;
    if (obs_q.size() != 2) begin n_bad++; $display("FAIL b2b_pulse_count: got %0d want 2", obs_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL b2b_result: no result want %h", e); end
      else begin
        g = obs_q.pop_front();
        if (g !== e) begin n_bad++; $display("FAIL b2b_result: got %h want %h", g, e); end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid;
    int lat, fl;
    logic [31:0] e, g;
    @(posedge clk); #1;
    start_i = 1'b1; op_i = 3'd4; rs1_i = 32'd500; rs2_i = 32'd3;
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if (ready_o !== 1'b0) begin n_bad++; $display("FAIL midrst_ready: got %b want 0", ready_o); end
    n_cmp++;
    if (result_o !== 32'h0) begin n_bad++; $display("FAIL midrst_result: got %h want 0", result_o); end
    n_cmp++;
    if (stallreq_o !== 1'b0) begin n_bad++; $display("FAIL midrst_stall: got %b want 0", stallreq_o); end
    start_i = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (40) @(negedge clk);
    n_cmp++;
    if (obs_q.size() != 0) begin n_bad++; $display("FAIL midrst_no_ready: got %0d pulses want 0", obs_q.size()); end
    obs_q.delete();
    issue(3'd4, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, lat, fl);
    n_cmp++;
    if (lat !== 33) begin n_bad++; $display("FAIL midrst_div_latency: got %0d want 33", lat); end
    e = exp_q.pop_front();
    n_cmp++;
    if (obs_q.size() == 0) begin n_bad++; $display("FAIL midrst_div_result: no result want %h", e); end
    else begin
      g = obs_q.pop_front();
      if (g !== e) begin n_bad++; $display("FAIL midrst_div_result: got %h want %h", g, e); end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
